// File: rtl/uart_rx_ctrl_if.sv
// Host-side bus of the UART receive controller: receiver byte strobes in,
// pop handshake and status/interrupt out.
// master = receiver/host side, slave = uart_rx_ctrl.
interface uart_rx_ctrl_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          en;
    logic [7:0]    rx_data;
    logic          rx_we;
    logic          rd;
    logic          flush;
    logic          clr_ovr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          overrun;
    logic          timeout;
    logic          irq;

    modport master (
        output en, rx_data, rx_we, rd, flush, clr_ovr,
        input  rd_data, rd_valid, level, empty, full, overrun, timeout, irq
    );

    modport slave (
        input  en, rx_data, rx_we, rd, flush, clr_ovr,
        output rd_data, rd_valid, level, empty, full, overrun, timeout, irq
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers receiver bytes in a DEPTH-entry FIFO, serves
// host pops, tracks overrun and fill level, and raises a registered interrupt.
// Optional idle-character timeout is built when UART_RX_CTRL_TIMEOUT_EN is defined;
// otherwise timeout is tied to 0 and TIMEOUT is unused.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned THRESH  = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic           clk,
    input logic           rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;
    logic          overrun_q;
    logic          irq_q;
    logic          timeout_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign pop   = bus.rd & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push  = bus.en & bus.rx_we & (~full | pop);
    assign drop  = bus.en & bus.rx_we & full & ~pop & ~bus.flush;

    // Next fill level; flush wins over any push/pop.
    always_comb begin
        level_nxt = level_q;
        if (bus.flush) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = level_q + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level_q - 1'b1;
        end
    end

    // Storage array; no reset needed, contents are qualified by level.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    // Pointers, level, pop data and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            level_q    <= level_nxt;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    rd_data_q  <= mem[rd_ptr];
                    rd_valid_q <= 1'b1;
                end
            end
            // Set beats clear when both happen together.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_ovr) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StCount, StExpired} to_state_t;

    to_state_t     to_state;
    logic [CW-1:0] idle_cnt;

    // Idle-character timeout FSM; timeout_q is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_state  <= StIdle;
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (bus.flush) begin
            to_state  <= StIdle;
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (to_state)
                StIdle: begin
                    if (push) begin
                        to_state <= StCount;
                        idle_cnt <= '0;
                    end
                end
                StCount: begin
                    if (push || pop) begin
                        idle_cnt <= '0;
                        if (level_nxt == '0) begin
                            to_state <= StIdle;
                        end
                    end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
                        to_state  <= StExpired;
                        timeout_q <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                StExpired: begin
                    if (push || pop) begin
                        idle_cnt  <= '0;
                        timeout_q <= 1'b0;
                        to_state  <= (level_nxt == '0) ? StIdle : StCount;
                    end
                end
                default: begin
                    to_state  <= StIdle;
                    idle_cnt  <= '0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_q      = 1'b0;
`endif

    // Interrupt is registered from the current level/timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (level_q >= LW'(THRESH)) | timeout_q;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.level    = level_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.overrun  = overrun_q;
    assign bus.timeout  = timeout_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model.
module tb_uart_rx_ctrl;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned THRESH  = 8;
    localparam int unsigned TIMEOUT = 4096;
    localparam int unsigned LW      = $clog2(DEPTH) + 1;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_ctrl #(
        .DEPTH   (DEPTH),
        .THRESH  (THRESH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int passed;

    // Behavioural model state
    logic [7:0] m_q[$];
    logic [7:0] m_rd_data;
    bit         m_rd_valid;
    bit         m_overrun;
    bit         m_timeout;
    bit         m_irq;
    int         m_idle;

    task automatic model_reset();
        m_q.delete();
        m_rd_data  = 8'h00;
        m_rd_valid = 1'b0;
        m_overrun  = 1'b0;
        m_timeout  = 1'b0;
        m_irq      = 1'b0;
        m_idle     = 0;
    endtask

    // One clock edge of the model, from the pre-edge state and the applied inputs.
    task automatic model_edge(input bit en, input bit we, input logic [7:0] d,
                              input bit rd, input bit fl, input bit clr);
        bit was_full;
        bit pop;
        bit act;
        bit dropped;
        was_full   = (m_q.size() == DEPTH);
        pop        = rd && (m_q.size() != 0);
        m_irq      = (m_q.size() >= THRESH) || m_timeout;
        m_rd_valid = 1'b0;
        dropped    = 1'b0;
        if (fl) begin
            m_q.delete();
            m_idle = 0;
        end else begin
            act = 1'b0;
            if (pop) begin
                m_rd_data  = m_q.pop_front();
                m_rd_valid = 1'b1;
                act        = 1'b1;
            end
            if (en && we) begin
                if (!was_full || pop) begin
                    m_q.push_back(d);
                    act = 1'b1;
                end else begin
                    dropped = 1'b1;
                end
            end
            if (act) m_idle = 0;
            else if (m_idle < TIMEOUT) m_idle++;
        end
        if (dropped) m_overrun = 1'b1;
        else if (clr) m_overrun = 1'b0;
        m_timeout = TO_EN && (m_q.size() != 0) && (m_idle >= TIMEOUT);
    endtask

    // Apply inputs for one cycle; returns 1 ns after the sampling edge.
    task automatic step(input bit en, input bit we, input logic [7:0] d,
                        input bit rd, input bit fl, input bit clr);
        bus.en      = en;
        bus.rx_we   = we;
        bus.rx_data = d;
        bus.rd      = rd;
        bus.flush   = fl;
        bus.clr_ovr = clr;
        @(posedge clk);
        model_edge(en, we, d, rd, fl, clr);
        #1;
        bus.en      = 1'b0;
        bus.rx_we   = 1'b0;
        bus.rd      = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_ovr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.rx_we   = 1'b0;
        bus.rx_data = 8'h00;
        bus.rd      = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_ovr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 8;
        if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", bus.rd_data);
        else passed++;
        if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid);
        else passed++;
        if (bus.level !== '0) $display("FAIL reset_level got %0d want 0", bus.level);
        else passed++;
        if (bus.empty !== 1'b1) $display("FAIL reset_empty got %b want 1", bus.empty);
        else passed++;
        if (bus.full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.full);
        else passed++;
        if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", bus.overrun);
        else passed++;
        if (bus.timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", bus.timeout);
        else passed++;
        if (bus.irq !== 1'b0) $display("FAIL reset_irq got %b want 0", bus.irq);
        else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] exp_bytes [3];
        exp_bytes[0] = 8'h11;
        exp_bytes[1] = 8'h22;
        exp_bytes[2] = 8'h33;
        for (int i = 0; i < 3; i++) push(exp_bytes[i]);
        total++;
        if (bus.level !== LW'(3)) $display("FAIL basic_level got %0d want 3", bus.level);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            pop_one();
            total += 2;
            if (bus.rd_valid !== 1'b1) $display("FAIL basic_rd_valid[%0d] got %b want 1", i, bus.rd_valid);
            else passed++;
            if (bus.rd_data !== exp_bytes[i])
                $display("FAIL basic_rd_data[%0d] got %h want %h", i, bus.rd_data, exp_bytes[i]);
            else passed++;
        end
        idle_n(1);
        total += 3;
        if (bus.rd_valid !== 1'b0) $display("FAIL basic_rd_valid_drop got %b want 0", bus.rd_valid);
        else passed++;
        if (bus.empty !== 1'b1) $display("FAIL basic_empty got %b want 1", bus.empty);
        else passed++;
        if (bus.rd_data !== 8'h33) $display("FAIL basic_rd_hold got %h want 33", bus.rd_data);
        else passed++;
    endtask

    task automatic fill_full();
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d;
            d = 8'($urandom_range(1, 255));
            if (d == 8'hAA) d = 8'h55;
            push(d);
        end
    endtask

    task automatic drain_check(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            pop_one();
            total++;
            if (bus.rd_data !== m_rd_data)
                $display("FAIL %s_rd_data[%0d] got %h want %h", tag, i, bus.rd_data, m_rd_data);
            else passed++;
        end
    endtask

    task automatic test_overrun();
        fill_full();
        total++;
        if (bus.full !== 1'b1) $display("FAIL ovr_full got %b want 1", bus.full);
        else passed++;
        push(8'hAA);
        total += 2;
        if (bus.overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", bus.overrun);
        else passed++;
        if (bus.level !== LW'(DEPTH)) $display("FAIL ovr_level got %0d want %0d", bus.level, DEPTH);
        else passed++;
        drain_check("ovr_drop");
        total++;
        if (bus.rd_data === 8'hAA) $display("FAIL ovr_dropped_byte got %h want not aa", bus.rd_data);
        else passed++;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.overrun !== 1'b0) $display("FAIL ovr_clear got %b want 0", bus.overrun);
        else passed++;
        fill_full();
        step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        total += 2;
        if (bus.overrun !== 1'b0) $display("FAIL ovr_poppush got %b want 0", bus.overrun);
        else passed++;
        if (bus.level !== LW'(DEPTH)) $display("FAIL ovr_poppush_level got %0d want %0d", bus.level, DEPTH);
        else passed++;
        drain_check("ovr_keep");
        total++;
        if (bus.rd_data !== 8'hAA) $display("FAIL ovr_last_byte got %h want aa", bus.rd_data);
        else passed++;
    endtask

    task automatic test_irq();
        for (int i = 0; i < THRESH - 1; i++) push(8'($urandom));
        idle_n(2);
        total++;
        if (bus.irq !== 1'b0) $display("FAIL irq_below got %b want 0", bus.irq);
        else passed++;
        push(8'($urandom));
        total++;
        if (bus.irq !== 1'b0) $display("FAIL irq_lag got %b want 0", bus.irq);
        else passed++;
        idle_n(1);
        total++;
        if (bus.irq !== 1'b1) $display("FAIL irq_rise got %b want 1", bus.irq);
        else passed++;
        pop_one();
        total++;
        if (bus.irq !== 1'b1) $display("FAIL irq_hold got %b want 1", bus.irq);
        else passed++;
        idle_n(1);
        total++;
        if (bus.irq !== 1'b0) $display("FAIL irq_fall got %b want 0", bus.irq);
        else passed++;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        push(8'h3C);
        idle_n(TIMEOUT - 1);
        total++;
        if (bus.timeout !== 1'b0) $display("FAIL to_early got %b want 0", bus.timeout);
        else passed++;
        idle_n(1);
`ifdef UART_RX_CTRL_TIMEOUT_EN
        total += 2;
        if (bus.timeout !== 1'b1) $display("FAIL to_rise got %b want 1", bus.timeout);
        else passed++;
        if (bus.irq !== 1'b0) $display("FAIL to_irq_lag got %b want 0", bus.irq);
        else passed++;
        idle_n(1);
        total++;
        if (bus.irq !== 1'b1) $display("FAIL to_irq_rise got %b want 1", bus.irq);
        else passed++;
        pop_one();
        total++;
        if (bus.timeout !== 1'b0) $display("FAIL to_clear got %b want 0", bus.timeout);
        else passed++;
        idle_n(1);
        total++;
        if (bus.irq !== 1'b0) $display("FAIL to_irq_clear got %b want 0", bus.irq);
        else passed++;
        idle_n(TIMEOUT + 4);
        total++;
        if (bus.timeout !== 1'b0) $display("FAIL to_idle_stays got %b want 0", bus.timeout);
        else passed++;
`else
        idle_n(8);
        total += 2;
        if (bus.timeout !== 1'b0) $display("FAIL to_disabled got %b want 0", bus.timeout);
        else passed++;
        if (bus.irq !== 1'b0) $display("FAIL to_disabled_irq got %b want 0", bus.irq);
        else passed++;
        pop_one();
`endif
    endtask

    task automatic test_empty_cases();
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        total += 2;
        if (bus.rd_valid !== 1'b0) $display("FAIL empty_bypass_valid got %b want 0", bus.rd_valid);
        else passed++;
        if (bus.level !== LW'(1)) $display("FAIL empty_bypass_level got %0d want 1", bus.level);
        else passed++;
        pop_one();
        total++;
        if (bus.rd_data !== 8'h77) $display("FAIL empty_stored got %h want 77", bus.rd_data);
        else passed++;
        pop_one();
        total += 3;
        if (bus.rd_valid !== 1'b0) $display("FAIL empty_rd_valid got %b want 0", bus.rd_valid);
        else passed++;
        if (bus.level !== '0) $display("FAIL empty_rd_level got %0d want 0", bus.level);
        else passed++;
        if (bus.rd_data !== 8'h77) $display("FAIL empty_rd_data got %h want 77", bus.rd_data);
        else passed++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push(8'($urandom));
        step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        total += 3;
        if (bus.level !== '0) $display("FAIL flush_level got %0d want 0", bus.level);
        else passed++;
        if (bus.empty !== 1'b1) $display("FAIL flush_empty got %b want 1", bus.empty);
        else passed++;
        if (bus.rd_data !== m_rd_data) $display("FAIL flush_rd_data got %h want %h", bus.rd_data, m_rd_data);
        else passed++;
        push(8'h01);
        pop_one();
        total++;
        if (bus.rd_data !== 8'h01) $display("FAIL flush_discard got %h want 01", bus.rd_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
        for (int i = 0; i < 8; i++) begin
            pop_one();
            total += 2;
            if (bus.rd_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", i, bus.rd_valid);
            else passed++;
            if (bus.rd_data !== m_rd_data)
                $display("FAIL b2b_data[%0d] got %h want %h", i, bus.rd_data, m_rd_data);
            else passed++;
        end
        total++;
        if (bus.empty !== 1'b1) $display("FAIL b2b_empty got %b want 1", bus.empty);
        else passed++;
    endtask

    task automatic test_random();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 600; n++) begin
            bit en, we, rd, fl, clr;
            en  = ($urandom_range(0, 9) != 0);
            we  = ($urandom_range(0, 9) < 6);
            rd  = ($urandom_range(0, 9) < 4);
            fl  = ($urandom_range(0, 63) == 0);
            clr = ($urandom_range(0, 19) == 0);
            step(en, we, 8'($urandom), rd, fl, clr);
            total += 7;
            if (bus.level !== LW'(m_q.size()))
                $display("FAIL rand_level[%0d] got %0d want %0d", n, bus.level, m_q.size());
            else passed++;
            if (bus.full !== (m_q.size() == DEPTH))
                $display("FAIL rand_full[%0d] got %b want %b", n, bus.full, m_q.size() == DEPTH);
            else passed++;
            if (bus.rd_valid !== m_rd_valid)
                $display("FAIL rand_rd_valid[%0d] got %b want %b", n, bus.rd_valid, m_rd_valid);
            else passed++;
            if (bus.rd_data !== m_rd_data)
                $display("FAIL rand_rd_data[%0d] got %h want %h", n, bus.rd_data, m_rd_data);
            else passed++;
            if (bus.overrun !== m_overrun)
                $display("FAIL rand_overrun[%0d] got %b want %b", n, bus.overrun, m_overrun);
            else passed++;
            if (bus.timeout !== m_timeout)
                $display("FAIL rand_timeout[%0d] got %b want %b", n, bus.timeout, m_timeout);
            else passed++;
            if (bus.irq !== m_irq)
                $display("FAIL rand_irq[%0d] got %b want %b", n, bus.irq, m_irq);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        fill_full();
        push(8'hAA);
        pop_one();
        bus.en    = 1'b1;
        bus.rx_we = 1'b1;
        bus.rd    = 1'b1;
        #2 rst = 1'b1;
        #1;
        total += 7;
        if (bus.rd_data !== 8'h00) $display("FAIL mid_rd_data got %h want 00", bus.rd_data);
        else passed++;
        if (bus.rd_valid !== 1'b0) $display("FAIL mid_rd_valid got %b want 0", bus.rd_valid);
        else passed++;
        if (bus.level !== '0) $display("FAIL mid_level got %0d want 0", bus.level);
        else passed++;
        if (bus.empty !== 1'b1) $display("FAIL mid_empty got %b want 1", bus.empty);
        else passed++;
        if (bus.full !== 1'b0) $display("FAIL mid_full got %b want 0", bus.full);
        else passed++;
        if (bus.overrun !== 1'b0) $display("FAIL mid_overrun got %b want 0", bus.overrun);
        else passed++;
        if (bus.irq !== 1'b0) $display("FAIL mid_irq got %b want 0", bus.irq);
        else passed++;
        do_reset();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        test_reset();
        test_basic();
        test_overrun();
        test_irq();
        test_timeout();
        test_empty_cases();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller between the UART byte receiver and the host bus. It accepts the one-cycle byte strobes produced by the receiver and buffers them in a DEPTH-entry FIFO. It serves host pops and tracks overrun, fill level and an idle-character timeout. From these it raises a single registered interrupt.

## Interface
- DEPTH, 16, FIFO entries; power of two, >= 2
- THRESH, 8, irq fires when level >= THRESH; range 1..DEPTH
- TIMEOUT, 4096, idle cycles with data pending before timeout; >= 2
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = accept receiver bytes; 0 = rx_we ignored
- rx_data  in  8  received byte, valid with rx_we
- rx_we  in  1  one-cycle byte strobe from receiver
- rd  in  1  pop request
- rd_data  out  8  last popped byte, registered
- rd_valid  out  1  one-cycle pulse: rd_data updated
- level  out  $clog2(DEPTH)+1  current entry count
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- flush  in  1  discard all entries
- clr_ovr  in  1  clear overrun
- overrun  out  1  sticky: byte dropped while full
- timeout  out  1  idle timeout pending
- irq  out  1  registered: (level >= THRESH) | timeout

## Operation
- Push happens when en & rx_we & (~full | pop). Pop happens when rd & ~empty.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Level is a separate counter.
- Push and pop in the same cycle: both take effect and level is unchanged. This also applies when full: the pop frees the slot, the byte is stored, and no overrun is flagged.
- Push and pop in the same cycle while empty: the byte is stored, the pop is ignored, and rd_valid stays 0. There is no bypass path.
- rd while empty is ignored, with no side effects.
- en & rx_we while full with no pop: the byte is dropped and overrun is set. rx_we with en=0 is dropped silently.
- overrun: a set and clr_ovr in the same cycle resolves to set.
- flush has priority over push and pop that cycle. It zeroes the pointers and level, returns the timeout FSM to IDLE and clears timeout. It does not touch overrun or rd_data.
- Timeout FSM, with an idle counter sized to TIMEOUT:
  - IDLE: FIFO empty, counter 0. A push moves to COUNT.
  - COUNT: counter increments each cycle. Any push or pop clears the counter and stays in COUNT, or goes to IDLE if the FIFO becomes empty. Counter == TIMEOUT-1 with no push/pop moves to EXPIRED.
  - EXPIRED: timeout=1. A push or pop goes to COUNT with counter 0, or to IDLE if the FIFO becomes empty.
  - flush moves to IDLE from any state.
- Reset mid-operation clears everything immediately. Bytes in flight are lost.

## Timing
- Reset values: rd_data=0, rd_valid=0, level=0, empty=1, full=0, overrun=0, timeout=0, irq=0.
- A push or pop in cycle N is reflected in level/empty/full in cycle N+1.
- A pop in cycle N gives rd_valid=1 and the new rd_data in cycle N+1. rd_data holds until the next pop.
- overrun rises in cycle N+1 after the dropped strobe.
- timeout rises exactly TIMEOUT cycles after the last push/pop, given no further activity.
- irq is registered from the N+1 values. It therefore lags level/timeout by one cycle and clears one cycle after both conditions drop.
- Back-to-back pops every cycle are supported at full rate.

## Configuration
- UART_RX_CTRL_TIMEOUT_EN:
  - Defined: timeout FSM and counter are present, as above.
  - Undefined: no FSM or counter. timeout is tied to 0 and irq = (level >= THRESH), still registered. The TIMEOUT parameter is unused.

## Test plan
- Reset then push 0x11,0x22,0x33 and pop 3x → rd_data sequence 0x11,0x22,0x33, each with rd_valid one cycle after rd; empty=1 after.
- Fill 16 bytes, then push 0xAA without rd → full=1, overrun=1, 0xAA absent. Repeat with rd in the same cycle → no overrun; level stays 16 and 0xAA is the last byte out.
- Push 7 bytes → irq=0. Push an 8th → irq=1 two cycles after the strobe. Pop 1 → irq=0 two cycles later.
- (TIMEOUT_EN) Push 1 byte and wait → timeout=1 at exactly 4096 cycles after the push, irq=1 one cycle later. A pop clears both and the FSM goes to IDLE.
- Push while empty with rd in the same cycle → rd_valid=0, level=1. rd while empty → no change.
- Push 5 bytes, then flush together with rx_we → level=0 next cycle, byte discarded. Assert rst mid-transfer → all outputs at reset values immediately.
